// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Pipelined resolution of RV32 conditional branches. Each accepted branch is
// resolved combinationally at the input (condition, target, redirect PC and
// mispredict/misaligned/illegal flags). The result then travels through
// LATENCY registered stages to the output. Each stage has its own valid bit.
// Saturating counters track resolved branches and resolved mispredicts.
//
// Parameters
//   DWIDTH   operand width
//   AWIDTH   PC / target width
//   LATENCY  register stages from input accept to output valid (1..4)
//   CWIDTH   statistics counter width
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_in_valid/o_in_ready   input handshake
//   i_rs1_data, i_rs2_data  compared operands
//   i_funct3                branch type
//   i_branch_pc/imm         branch PC and sign-extended B-immediate
//   i_pred_taken            front-end prediction
//   i_flush                 kill in-flight and incoming work
//   o_out_valid/i_out_ready output handshake
//   o_taken .. o_illegal    resolved result of the branch at the output
//   o_branch_count          transferred results, saturating
//   o_mispred_count         transferred mispredicts, saturating
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int LATENCY = 2,
    parameter int CWIDTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DWIDTH-1:0] i_rs1_data,
    input  logic [DWIDTH-1:0] i_rs2_data,
    input  logic [2:0]        i_funct3,
    input  logic [AWIDTH-1:0] i_branch_pc,
    input  logic [AWIDTH-1:0] i_branch_imm,
    input  logic              i_pred_taken,
    input  logic              i_flush,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_taken,
    output logic [AWIDTH-1:0] o_target,
    output logic [AWIDTH-1:0] o_redirect_pc,
    output logic              o_mispredict,
    output logic              o_misaligned,
    output logic              o_illegal,
    output logic [CWIDTH-1:0] o_branch_count,
    output logic [CWIDTH-1:0] o_mispred_count
);

    typedef struct packed {
        logic              taken;
        logic [AWIDTH-1:0] target;
        logic [AWIDTH-1:0] redirect;
        logic              mispredict;
        logic              misaligned;
        logic              illegal;
    } result_t;

    // ---------------- combinational resolution at the input ----------------
    logic              w_eq;
    logic              w_lt;
    logic              w_ltu;
    logic              w_cond;
    logic              w_illegal;
    logic [AWIDTH-1:0] w_target;
    logic [AWIDTH-1:0] w_seq_pc;
    result_t           w_res;

    always_comb begin
        w_eq      = (i_rs1_data == i_rs2_data);
        w_lt      = ($signed(i_rs1_data) < $signed(i_rs2_data));
        w_ltu     = (i_rs1_data < i_rs2_data);
        w_illegal = (i_funct3[2:1] == 2'b01);
        w_target  = i_branch_pc + i_branch_imm;
        w_seq_pc  = i_branch_pc + AWIDTH'(4);
        case (i_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;   // illegal encodings never take
        endcase
        w_res.taken      = w_cond;
        w_res.target     = w_target;
        w_res.redirect   = w_cond ? w_target : w_seq_pc;
        w_res.mispredict = (w_cond != i_pred_taken);
        w_res.misaligned = w_cond && (w_target[1:0] != 2'b00);
        w_res.illegal    = w_illegal;
    end

    // ---------------- pipeline stages ----------------
    logic [LATENCY-1:0] r_valid;
    result_t            r_data [LATENCY];
    logic [LATENCY-1:0] w_load;
    logic [LATENCY-1:0] w_src_valid;
    result_t            w_src_data [LATENCY];

    // A stage may load when it is empty or its own contents move on this
    // cycle. Computing the chain from the output backwards in one block makes
    // In_Ready a purely combinational function of Out_Ready and the valids.
    always_comb begin
        w_load = '0;
        w_load[LATENCY-1] = ~r_valid[LATENCY-1] | i_out_ready;
        for (int i = LATENCY - 2; i >= 0; i--) begin
            w_load[i] = ~r_valid[i] | w_load[i+1];
        end
    end

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign w_src_valid[gi] = i_in_valid;
                assign w_src_data[gi]  = w_res;
            end else begin : g_chain
                assign w_src_valid[gi] = r_valid[gi-1];
                assign w_src_data[gi]  = r_data[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                if (i_flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_valid[i] <= w_src_valid[i];
                end
                // Payload only moves with a real transaction, so a stalled
                // output stage keeps its value untouched.
                if (!i_flush && w_load[i] && w_src_valid[i]) begin
                    r_data[i] <= w_src_data[i];
                end
            end
        end
    end

    // ---------------- statistics ----------------
    logic              w_out_xfer;
    logic [CWIDTH-1:0] r_branch_cnt;
    logic [CWIDTH-1:0] r_mispred_cnt;

    // A result leaving while Flush is asserted is treated as killed.
    assign w_out_xfer = r_valid[LATENCY-1] & i_out_ready & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_branch_cnt != {CWIDTH{1'b1}}) begin
                r_branch_cnt <= r_branch_cnt + CWIDTH'(1);
            end
            if (r_data[LATENCY-1].mispredict && (r_mispred_cnt != {CWIDTH{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + CWIDTH'(1);
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_in_ready      = w_load[0];
    assign o_out_valid     = r_valid[LATENCY-1];
    assign o_taken         = r_data[LATENCY-1].taken;
    assign o_target        = r_data[LATENCY-1].target;
    assign o_redirect_pc   = r_data[LATENCY-1].redirect;
    assign o_mispredict    = r_data[LATENCY-1].mispredict;
    assign o_misaligned    = r_data[LATENCY-1].misaligned;
    assign o_illegal       = r_data[LATENCY-1].illegal;
    assign o_branch_count  = r_branch_cnt;
    assign o_mispred_count = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit (LATENCY=2, CWIDTH=4 so that the
// saturation case is reachable). Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LAT = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] rs1 = '0;
    logic [DW-1:0] rs2 = '0;
    logic [2:0]    funct3 = '0;
    logic [AW-1:0] pc = '0;
    logic [AW-1:0] imm = '0;
    logic          pred = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          taken;
    logic [AW-1:0] target;
    logic [AW-1:0] redirect;
    logic          mispredict;
    logic          misaligned;
    logic          illegal;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispred_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DWIDTH (DW),
        .AWIDTH (AW),
        .LATENCY(LAT),
        .CWIDTH (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_rs1_data     (rs1),
        .i_rs2_data     (rs2),
        .i_funct3       (funct3),
        .i_branch_pc    (pc),
        .i_branch_imm   (imm),
        .i_pred_taken   (pred),
        .i_flush        (flush),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_taken        (taken),
        .o_target       (target),
        .o_redirect_pc  (redirect),
        .o_mispredict   (mispredict),
        .o_misaligned   (misaligned),
        .o_illegal      (illegal),
        .o_branch_count (branch_count),
        .o_mispred_count(mispred_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, act);
        end
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [AW-1:0] p,
                                input logic [AW-1:0] i, input logic pt);
        in_valid = 1'b1;
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        pc       = p;
        imm      = i;
        pred     = pt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    // Compare sweep: 0xFFFFFFFF vs 1 is -1 < 1 signed, max > 1 unsigned.
    logic [2:0] sw_f3 [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001};
    logic       sw_tk [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int acc;
        int oi;
        int idx;

        // ---------------- reset state ----------------
        do_reset();
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_redirect", redirect, 0);
        check_eq("rst_branch_count", branch_count, 0);

        // ---------------- compare sweep ----------------
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("sweep_not_yet_valid", out_valid, 0);
            if (k >= 2) begin
                idx = k - 2;
                check_eq($sformatf("sweep%0d_valid", idx), out_valid, 1);
                check_eq($sformatf("sweep%0d_taken", idx), taken, sw_tk[idx]);
                check_eq($sformatf("sweep%0d_redirect", idx), redirect,
                         sw_tk[idx] ? 64'h1008 : 64'h1004);
                check_eq($sformatf("sweep%0d_mispredict", idx), mispredict, sw_tk[idx]);
            end
            if (k < 6) drive_branch(sw_f3[k], 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'h8, 1'b0);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("sweep_branch_count", branch_count, 6);
        check_eq("sweep_mispred_count", mispred_count, 3);

        // ---------------- target / redirect ----------------
        do_reset();
        out_ready = 1'b1;
        drive_branch(3'b000, 32'd5, 32'd5, 32'h100, 32'hFFFF_FFF0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("tgt_valid", out_valid, 1);
        check_eq("tgt_target", target, 64'hF0);
        check_eq("tgt_redirect", redirect, 64'hF0);
        check_eq("tgt_mispredict", mispredict, 1);
        check_eq("tgt_misaligned", misaligned, 0);
        @(negedge clk);
        check_eq("tgt_mispred_count", mispred_count, 1);
        check_eq("tgt_branch_count", branch_count, 1);
        drive_branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h6, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("mis_target", target, 64'h106);
        check_eq("mis_redirect", redirect, 64'h106);
        check_eq("mis_misaligned", misaligned, 1);

        // ---------------- backpressure ----------------
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check_eq($sformatf("bp_hold%0d_valid", c), out_valid, 1);
                check_eq($sformatf("bp_hold%0d_redirect", c), redirect, 64'h240);
            end
            drive_branch(3'b000, 32'd7, 32'd7, 32'h200 + 32'(4 * acc), 32'h40, 1'b1);
            #1;
            if (c == 4) check_eq("bp_in_ready_low", in_ready, 0);
            if (in_ready) acc++;
        end
        check_eq("bp_accepts_before_stall", acc, LAT);
        oi = 0;
        for (int c = 0; c < 30 && oi < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check_eq($sformatf("bp_out%0d_redirect", oi), redirect, 64'(32'h240 + 32'(4 * oi)));
                oi++;
            end
            out_ready = 1'b1;
            if (acc < 6) drive_branch(3'b000, 32'd7, 32'd7, 32'h200 + 32'(4 * acc), 32'h40, 1'b1);
            else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) acc++;
        end
        check_eq("bp_all_results_out", oi, 6);
        @(negedge clk);
        check_eq("bp_branch_count", branch_count, 6);

        // ---------------- flush ----------------
        do_reset();
        out_ready = 1'b1;
        drive_branch(3'b000, 32'd1, 32'd1, 32'h400, 32'h20, 1'b0);
        @(negedge clk);
        drive_branch(3'b000, 32'd1, 32'd1, 32'h404, 32'h20, 1'b0);
        @(negedge clk);
        drive_branch(3'b000, 32'd1, 32'd1, 32'h408, 32'h20, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("flush_valid_c%0d", c), out_valid, 0);
            @(negedge clk);
        end
        check_eq("flush_branch_count", branch_count, 0);
        check_eq("flush_mispred_count", mispred_count, 0);
        drive_branch(3'b000, 32'd1, 32'd1, 32'h500, 32'h20, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_flush_valid", out_valid, 1);
        check_eq("post_flush_redirect", redirect, 64'h520);
        @(negedge clk);
        check_eq("post_flush_branch_count", branch_count, 1);

        // ---------------- saturation / illegal ----------------
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                idx = k - 2;
                check_eq($sformatf("ill%0d_valid", idx), out_valid, 1);
                if (idx == 0 || idx == 16) begin
                    check_eq($sformatf("ill%0d_illegal", idx), illegal, 1);
                    check_eq($sformatf("ill%0d_taken", idx), taken, 0);
                    check_eq($sformatf("ill%0d_redirect", idx), redirect, 64'(32'h304 + 32'(4 * idx)));
                    check_eq($sformatf("ill%0d_mispredict", idx), mispredict, 1);
                    check_eq($sformatf("ill%0d_misaligned", idx), misaligned, 0);
                end
            end
            if (k < 17) drive_branch(3'b010, 32'd3, 32'd3, 32'h300 + 32'(4 * k), 32'h10, 1'b1);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("sat_branch_count", branch_count, 15);
        check_eq("sat_mispred_count", mispred_count, 15);
        @(negedge clk);
        @(negedge clk);
        check_eq("sat_branch_count_held", branch_count, 15);
        check_eq("sat_mispred_count_held", mispred_count, 15);

        // ---------------- reset mid-stall ----------------
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_branch(3'b000, 32'd1, 32'd2, 32'h600 + 32'(4 * c), 32'h40, 1'b1);
        end
        @(negedge clk);
        #1;
        check_eq("stall_full_in_ready", in_ready, 0);
        check_eq("stall_full_valid", out_valid, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst2_out_valid", out_valid, 0);
        check_eq("rst2_in_ready", in_ready, 1);
        check_eq("rst2_taken", taken, 0);
        check_eq("rst2_target", target, 0);
        check_eq("rst2_redirect", redirect, 0);
        check_eq("rst2_mispredict", mispredict, 0);
        check_eq("rst2_misaligned", misaligned, 0);
        check_eq("rst2_illegal", illegal, 0);
        check_eq("rst2_branch_count", branch_count, 0);
        check_eq("rst2_mispred_count", mispred_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
